// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style main controller: one state per micro-step, outputs decoded from state.
// Optional jal/jr support is compiled in with `define CTRL_JAL_JR_EN.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst1,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUOperation,
  output logic       illegal
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CTRL_JAL_JR_EN
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
`endif

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB,
    BEQ, JMP, IMM_EX, IMM_WB
`ifdef CTRL_JAL_JR_EN
    , JAL, JR
`endif
  } state_e;

  typedef struct packed {
    logic       pc_load;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst1;
    logic       jal1;
    logic       mem_to_reg;
    logic       jal2;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic       illegal;
  } ctrl_t;

  state_e state_q, state_d;
  ctrl_t  ctl, ctl_o;

  always_comb begin
    state_d = FETCH;
    ctl     = '0;
    case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = 1'b1;
        ctl.alu_src_b = 2'd1;
        ctl.alu_op    = ALU_ADD;
        ctl.pc_load   = 1'b1;
        state_d       = DECODE;
      end
      DECODE: begin
        // Precompute the branch target while the opcode is decoded
        ctl.alu_src_b = 2'd3;
        ctl.alu_op    = ALU_ADD;
        case (opc)
          OP_R: begin
            state_d = R_EX;
`ifdef CTRL_JAL_JR_EN
            if (func == FN_JR) state_d = JR;
`endif
          end
          OP_LW, OP_SW:     state_d = MEM_ADR;
          OP_BEQ:           state_d = BEQ;
          OP_ADDI, OP_SLTI: state_d = IMM_EX;
          OP_J:             state_d = JMP;
`ifdef CTRL_JAL_JR_EN
          OP_JAL:           state_d = JAL;
`endif
          default: begin
            ctl.illegal = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      MEM_ADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'd2;
        ctl.alu_op    = ALU_ADD;
        state_d       = (opc == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
        state_d      = MEM_WB;
      end
      MEM_WB: ctl.reg_write = 1'b1;
      MEM_WR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      R_EX: begin
        ctl.alu_src_a = 1'b1;
        state_d       = R_WB;
        case (func)
          6'b100000: ctl.alu_op = ALU_ADD;
          6'b100010: ctl.alu_op = ALU_SUB;
          6'b100100: ctl.alu_op = ALU_AND;
          6'b100101: ctl.alu_op = ALU_OR;
          6'b101010: ctl.alu_op = ALU_SLT;
          default: begin
            ctl.illegal = 1'b1;
            state_d     = FETCH;
          end
        endcase
      end
      R_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.reg_dst1   = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      BEQ: begin
        // Branch taken is resolved in this cycle from the live zero flag
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = ALU_SUB;
        ctl.pc_src    = 2'd2;
        ctl.pc_load   = zero;
      end
      IMM_EX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'd2;
        ctl.alu_op    = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d       = IMM_WB;
      end
      IMM_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      JMP: begin
        ctl.pc_load = 1'b1;
        ctl.pc_src  = 2'd1;
      end
`ifdef CTRL_JAL_JR_EN
      JAL: begin
        ctl.pc_load   = 1'b1;
        ctl.reg_write = 1'b1;
        ctl.jal1      = 1'b1;
        ctl.jal2      = 1'b1;
        ctl.pc_src    = 2'd1;
      end
      JR: begin
        ctl.pc_load = 1'b1;
        ctl.pc_src  = 2'd3;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // Reset silences every strobe immediately, not just at the next edge
  assign ctl_o = rst ? ctl : '0;

  assign PCLoad       = ctl_o.pc_load;
  assign IorD         = ctl_o.iord;
  assign MemRead      = ctl_o.mem_read;
  assign MemWrite     = ctl_o.mem_write;
  assign IRWrite      = ctl_o.ir_write;
  assign RegDst1      = ctl_o.reg_dst1;
  assign JalSig1      = ctl_o.jal1;
  assign MemToReg     = ctl_o.mem_to_reg;
  assign JalSig2      = ctl_o.jal2;
  assign RegWrite     = ctl_o.reg_write;
  assign ALUSrcA      = ctl_o.alu_src_a;
  assign ALUSrcB      = ctl_o.alu_src_b;
  assign PCSrc        = ctl_o.pc_src;
  assign ALUOperation = ctl_o.alu_op;
  assign illegal      = ctl_o.illegal;

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset.
REQ-004 opc  input  6  IR[31:26].
REQ-005 func  input  6  IR[5:0].
REQ-006 zero  input  1  ALU zero flag.
REQ-007 PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst1, JalSig1, MemToReg, JalSig2, RegWrite, ALUSrcA  output  1 each  datapath controls.
REQ-008 ALUSrcB  output  2  B-operand select: 0=B, 1=4, 2=SE, 3=SE<<2.
REQ-009 PCSrc  output  2  PC-source select: 0=ALU result, 1=jump address, 2=ALUOut, 3=A.
REQ-010 ALUOperation  output  3  ALU opcode: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-011 illegal  output  1  one-cycle pulse on an unsupported opc or func.

Function
REQ-012 The state machine SHALL have these states:
- FETCH
- DECODE
- MEM_ADR
- MEM_RD
- MEM_WB
- MEM_WR
- R_EX
- R_WB
- BEQ
- JMP
- IMM_EX
- IMM_WB
- JAL
- JR
REQ-013 Every output SHALL be 0 in every state unless this section lists it.
REQ-014 FETCH SHALL assert MemRead, IRWrite, ALUSrcB=1, ALUOperation=add and PCLoad, with IorD=0, ALUSrcA=0 and PCSrc=0, and SHALL go to DECODE.
REQ-015 DECODE SHALL drive ALUSrcA=0, ALUSrcB=3 and ALUOperation=add, and SHALL branch on opc as follows:
- 000000 → R_EX, or → JR when func=001000
- 100011 or 101011 → MEM_ADR
- 000100 → BEQ
- 001000 or 001010 → IMM_EX
- 000010 → JMP
- 000011 → JAL
- any other opc → FETCH, with illegal=1
REQ-016 MEM_ADR SHALL drive ALUSrcA=1, ALUSrcB=2 and ALUOperation=add, then go to MEM_RD when opc=100011, otherwise to MEM_WR.
REQ-017 MEM_RD SHALL assert IorD and MemRead, then go to MEM_WB.
REQ-018 MEM_WB SHALL assert RegWrite with RegDst1=0 and MemToReg=0, then go to FETCH.
REQ-019 MEM_WR SHALL assert IorD and MemWrite, then go to FETCH.
REQ-020 R_EX SHALL drive ALUSrcA=1 and ALUSrcB=0, with ALUOperation from func: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
REQ-021 When R_EX sees an unlisted func, it SHALL pulse illegal and go to FETCH; otherwise it SHALL go to R_WB.
REQ-022 R_WB SHALL assert RegWrite, RegDst1 and MemToReg, then go to FETCH.
REQ-023 BEQ SHALL drive ALUSrcA=1, ALUSrcB=0, ALUOperation=sub, PCSrc=2 and PCLoad=zero (combinational, Mealy), then go to FETCH.
REQ-024 IMM_EX SHALL drive ALUSrcA=1 and ALUSrcB=2, with ALUOperation add for opc 001000 and slt for opc 001010, then go to IMM_WB.
REQ-025 IMM_WB SHALL assert RegWrite and MemToReg with RegDst1=0, then go to FETCH.
REQ-026 JMP SHALL assert PCLoad with PCSrc=1, then go to FETCH.
REQ-027 JAL SHALL assert PCLoad, RegWrite, JalSig1 and JalSig2 with PCSrc=1, then go to FETCH.
REQ-028 JR SHALL assert PCLoad with PCSrc=3, then go to FETCH.
REQ-029 Cycles per instruction SHALL be:
- lw 5
- sw, R-type and immediate 4
- beq, j, jal and jr 3
REQ-030 No state SHALL assert MemRead and MemWrite in the same cycle.

Reset
REQ-031 When rst=0, the state register SHALL go to FETCH asynchronously.
REQ-032 While rst=0, all outputs (including illegal) SHALL be forced to 0 combinationally.
REQ-033 The first FETCH cycle SHALL be the first clock cycle after rst deasserts.
REQ-034 An rst assertion in any state SHALL abort the instruction, with no further RegWrite, MemWrite or PCLoad until the next FETCH.

Configuration
REQ-035 The macro CTRL_JAL_JR_EN SHALL compile in jal/jr support.
REQ-036 When CTRL_JAL_JR_EN is defined, the JAL and JR states and their decode entries SHALL exist as specified above.
REQ-037 When CTRL_JAL_JR_EN is undefined:
- opc 000011 SHALL be decoded as illegal.
- R-type func 001000 SHALL be decoded as illegal.
- JalSig1, JalSig2 and PCSrc=3 SHALL never be asserted.
- The JAL and JR states SHALL be absent.

Verification
REQ-038 Reset then lw: hold rst=0 for 3 cycles with all outputs 0, then release with opc=100011 → the FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB sequence, RegWrite=1 only in cycle 5, then FETCH.
REQ-039 beq: opc=000100 with zero=1 → PCLoad=1 and PCSrc=2 in cycle 3; repeat with zero=0 → PCLoad=0 in cycle 3.
REQ-040 R-type sweep: opc=0 with each listed func → ALUOperation 010, 110, 000, 001, 111 in R_EX, then R_WB with RegDst1=1 and MemToReg=1; func=000111 → illegal=1 and next state FETCH.
REQ-041 jal: opc=000011 with CTRL_JAL_JR_EN defined → in cycle 3 JalSig1=1, JalSig2=1, RegWrite=1, PCSrc=1 and PCLoad=1; without the macro → illegal=1 in DECODE.
REQ-042 Reset mid-instruction: assert rst during MEM_WR with MemWrite=1 → MemWrite=0 immediately, and the state after release is FETCH.
REQ-043 Undefined opcode 111111 → illegal pulses for 1 cycle in DECODE, no write strobes occur, and the next state is FETCH.
